// File: rtl/bitwise_pkg.sv
// Shared types for the pipelined bitwise logic unit: op encoding, flag layout
// and the pipeline depth limit.
package bitwise_pkg;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_ORR = 2'b01,
    OP_EOR = 2'b10,
    OP_BIC = 2'b11
  } logic_op_e;

  typedef struct packed {
    logic n;
    logic z;
  } nz_flags_t;

  localparam int STAGES_MAX = 4;

endpackage

// File: rtl/logic_pipe_stage.sv
// One valid/ready register slice carrying {set_flags, result}.
// Handshake: the slice loads its source when ready_i is high; a low ready_i holds everything.
module logic_pipe_stage
  import bitwise_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             flush_i,
  input  logic             src_valid_i,
  input  logic [WIDTH:0]   src_data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH:0]   data_o
);

  logic           valid_q, valid_d;
  logic [WIDTH:0] data_q, data_d;

  // Flush only drops the valid bit; data bits keep their last contents.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (ready_i) begin
      valid_d = src_valid_i;
      if (src_valid_i) begin
        data_d = src_data_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/bitwise_logic_pipe.sv
// Pipelined AND/ORR/EOR/BIC unit with per-stage valid/ready, flush and an N/Z
// flag register updated when a flag-setting op retires.
module bitwise_logic_pipe
  import bitwise_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       op,
  input  logic             set_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [1:0]       flags
);

  logic [WIDTH-1:0] kernel;
  logic [WIDTH:0]   stage_data [0:STAGES];
  logic [STAGES:1]  stage_valid;
  logic [STAGES:1]  stage_ready;
  logic             accept;
  logic             retire;
  nz_flags_t        flags_q, flags_d;

  always_comb begin
    case (logic_op_e'(op))
      OP_AND:  kernel = A & B;
      OP_ORR:  kernel = A | B;
      OP_EOR:  kernel = A ^ B;
      OP_BIC:  kernel = A & ~B;
      default: kernel = A & B;
    endcase
  end

  // An empty stage is always ready, so bubbles collapse even behind a stall.
  always_comb begin
    stage_ready         = '0;
    stage_ready[STAGES] = !stage_valid[STAGES] || out_ready;
    for (int k = STAGES - 1; k >= 1; k--) begin
      stage_ready[k] = !stage_valid[k] || stage_ready[k+1];
    end
  end

  assign in_ready      = stage_ready[1] && !flush;
  assign accept        = in_valid && in_ready;
  assign stage_data[0] = {set_flags, kernel};

  for (genvar k = 1; k <= STAGES; k++) begin : g_stage
    logic src_valid;
    if (k == 1) begin : g_first
      assign src_valid = accept;
    end else begin : g_next
      assign src_valid = stage_valid[k-1];
    end

    logic_pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk_i      (clk),
      .reset_i    (reset),
      .flush_i    (flush),
      .src_valid_i(src_valid),
      .src_data_i (stage_data[k-1]),
      .ready_i    (stage_ready[k]),
      .valid_o    (stage_valid[k]),
      .data_o     (stage_data[k])
    );
  end

  assign out_valid = stage_valid[STAGES];
  assign result    = stage_data[STAGES][WIDTH-1:0];
  assign retire    = out_valid && out_ready;

  // A retire in a flush cycle still completes, so flags ignore flush.
  always_comb begin
    flags_d = flags_q;
    if (retire && stage_data[STAGES][WIDTH]) begin
      flags_d.n = result[WIDTH-1];
      flags_d.z = (result == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= '0;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign flags = flags_q;

endmodule

// File: tb/tb_bitwise_logic_pipe.sv
// Bench for bitwise_logic_pipe (WIDTH=64, STAGES=2): vector table, hand-written
// latency/backpressure/flag/flush/reset sequences, and a result/flag scoreboard.
module tb_bitwise_logic_pipe;

  localparam int W = 64;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sf;
    logic [W-1:0] exp;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset, flush, in_valid, in_ready, set_flags, out_valid, out_ready;
  logic [W-1:0] A, B, result;
  logic [1:0]   op, flags;

  logic [W:0]   exp_q[$];
  logic [W-1:0] cur_exp;
  logic [1:0]   exp_flags;
  logic         mon_en = 1'b0;
  int           n_checks = 0;
  int           n_fail = 0;
  int           retired = 0;
  vec_t         tbl[8];

  bitwise_logic_pipe #(.WIDTH(W), .STAGES(2)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .op(op), .set_flags(set_flags), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] a, b);
    case (o)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return a & ~b;
    endcase
  endfunction

  // Scoreboard: sampled on the falling edge, models what the next rising edge does.
  always @(negedge clk) begin
    logic [W:0] e;
    if (mon_en) begin
      chk("flags", {62'd0, flags}, {62'd0, exp_flags});
      if (reset) begin
        exp_q.delete();
        exp_flags = 2'b00;
      end else begin
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_retire", 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk("result", result, e[W-1:0]);
            if (e[W]) exp_flags = {e[W-1], (e[W-1:0] == '0)};
            retired++;
          end
        end
        if (flush) begin
          chk("in_ready_in_flush", {63'd0, in_ready}, 64'd0);
          exp_q.delete();
        end else if (in_valid && in_ready) begin
          exp_q.push_back({set_flags, cur_exp});
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [1:0] o, input logic [W-1:0] a_v, b_v, input logic sf,
                      input logic [W-1:0] e, output int waited);
    in_valid = 1'b1; op = o; A = a_v; B = b_v; set_flags = sf; cur_exp = e;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) chk("accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_rand(output int waited);
    logic [1:0]   o;
    logic [W-1:0] a_v, b_v;
    o   = 2'($urandom_range(0, 3));
    a_v = {$urandom(), $urandom()};
    b_v = {$urandom(), $urandom()};
    send(o, a_v, b_v, 1'($urandom_range(0, 1)), model(o, a_v, b_v), waited);
  endtask

  task automatic drain();
    int t = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && t < 50) begin
      t++;
      @(posedge clk); #1;
    end
    chk("drain", {32'd0, exp_q.size()}, 64'd0);
  endtask

  // Holds out_ready low for five cycles once two edges of the stream have passed.
  task automatic stall(input logic first_in_ready);
    logic [W-1:0] held;
    repeat (2) @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    held = result;
    chk("stall_in_ready_first", {63'd0, in_ready}, {63'd0, first_in_ready});
    repeat (4) begin
      @(negedge clk);
      chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
      chk("stall_valid", {63'd0, out_valid}, 64'd1);
      chk("stall_result_stable", result, held);
    end
    @(posedge clk); #1 out_ready = 1'b1;
  endtask

  initial begin
    int w;
    int t;
    int base;

    tbl[0] = '{2'b00, 64'h45, 64'h48, 1'b0, 64'h40};
    tbl[1] = '{2'b01, 64'h45, 64'h48, 1'b0, 64'h4D};
    tbl[2] = '{2'b10, 64'h45, 64'h48, 1'b0, 64'h0D};
    tbl[3] = '{2'b11, 64'h45, 64'h48, 1'b0, 64'h05};
    tbl[4] = '{2'b00, '1, '1, 1'b1, '1};
    tbl[5] = '{2'b10, '1, 64'd0, 1'b0, '1};
    tbl[6] = '{2'b01, 64'd0, 64'd0, 1'b0, 64'd0};
    tbl[7] = '{2'b11, 64'hA5A5, 64'hA5A5, 1'b1, 64'd0};

    // Reset held two cycles with an op presented.
    reset = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    A = '1; B = '1; op = 2'b00; set_flags = 1'b1; cur_exp = '0; exp_flags = 2'b00;
    @(posedge clk); #1 mon_en = 1'b1;
    @(posedge clk); #1;
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_flags", {62'd0, flags}, 64'd0);
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("post_reset_in_ready", {63'd0, in_ready}, 64'd1);
    chk("post_reset_out_valid", {63'd0, out_valid}, 64'd0);
    @(posedge clk); #1;

    // Single-op latency.
    out_ready = 1'b1;
    in_valid = 1'b1; op = 2'b00; set_flags = 1'b0;
    A = 64'hF0F0F0F0F0F0F0F0; B = 64'hFF00FF00FF00FF00; cur_exp = 64'hF000F000F000F000;
    @(negedge clk);
    chk("lat_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("lat_early", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    chk("lat_valid", {63'd0, out_valid}, 64'd1);
    chk("lat_result", result, 64'hF000F000F000F000);
    @(negedge clk);
    chk("lat_one_cycle", {63'd0, out_valid}, 64'd0);
    @(posedge clk); #1;

    // Back-to-back table ops; results must emerge on consecutive cycles.
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          send(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].sf, tbl[i].exp, w);
          chk("b2b_in_ready", w, 64'd0);
          in_valid = 1'b1;
        end
        in_valid = 1'b0;
      end
      begin
        t = 0;
        @(negedge clk);
        while (!out_valid && t < 20) begin
          t++;
          @(negedge clk);
        end
        chk("b2b_first_valid", {63'd0, out_valid}, 64'd1);
        repeat (3) begin
          @(negedge clk);
          chk("b2b_consecutive", {63'd0, out_valid}, 64'd1);
        end
      end
    join
    for (int i = 4; i < 8; i++) send(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].sf, tbl[i].exp, w);
    drain();

    // Backpressure, continuous stream then one with a bubble after the first op.
    base = retired;
    fork
      for (int i = 0; i < 6; i++) send_rand(w);
      stall(1'b0);
    join
    drain();
    chk("bp_retired", retired - base, 64'd6);
    base = retired;
    fork
      begin
        send_rand(w);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) send_rand(w);
      end
      stall(1'b1);
    join
    drain();
    chk("bp_gap_retired", retired - base, 64'd6);

    // Flag sequence.
    send(2'b10, 64'h1234, 64'h1234, 1'b1, 64'd0, w);
    drain();
    chk("flags_zero", {62'd0, flags}, 64'h1);
    send(2'b01, 64'h8000000000000000, 64'd0, 1'b0, 64'h8000000000000000, w);
    drain();
    chk("flags_hold", {62'd0, flags}, 64'h1);
    send(2'b01, 64'h8000000000000000, 64'd0, 1'b1, 64'h8000000000000000, w);
    drain();
    chk("flags_neg", {62'd0, flags}, 64'h2);

    // Flush with two ops in flight and an op presented.
    out_ready = 1'b0;
    send(2'b01, 64'd1, 64'd0, 1'b1, 64'd1, w);
    send(2'b00, 64'd0, 64'd0, 1'b1, 64'd0, w);
    flush = 1'b1; in_valid = 1'b1; op = 2'b00; A = 64'd0; B = 64'd0; set_flags = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("flush_no_retire", {63'd0, out_valid}, 64'd0);
    end
    chk("flush_flags", {62'd0, flags}, 64'h2);
    @(posedge clk); #1;

    // Same again, dropped by reset instead.
    out_ready = 1'b0;
    send(2'b01, 64'h8000000000000000, 64'd0, 1'b1, 64'h8000000000000000, w);
    send(2'b01, 64'd5, 64'd0, 1'b1, 64'd5, w);
    reset = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1 reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_mid_flags", {62'd0, flags}, 64'd0);
    chk("rst_mid_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
